tapasco_dmi_initiator: RTL and testbench

TAPASCO_DMI_INITIATOR -- requirements
Module: tapasco_dmi_initiator

---
 rtl/tapasco_dmi_initiator.sv | 158 +++++++++++++++
 tb/tb_tapasco_dmi_initiator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tapasco_dmi_initiator.sv
// tapasco_dmi_initiator
//
// Turns single host commands (read or write of one DMI register) into one
// DMI request/response exchange and hands the outcome back to the host.
// One transaction is in flight at a time; a bounded wait on the DMI
// response converts a missing answer into an error result.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_*                 host command channel (valid/ready, wr, addr, wdata)
//   rsp_*                 host result channel (valid/ready, rdata, status,
//                         timeout flag)
//   busy_o                a transaction is in progress (FSM not IDLE)
//   stale_o               sticky: an unsolicited DMI response was discarded
//   dmi_req_*             DMI request channel (valid/ready, op, addr, data)
//   dmi_resp_*            DMI response channel (valid/ready, data, resp)
module tapasco_dmi_initiator #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_status_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  output logic                  stale_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output logic [1:0]            dmi_req_op_o,
  output logic [ADDR_WIDTH-1:0] dmi_req_addr_o,
  output logic [DATA_WIDTH-1:0] dmi_req_data_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  logic [DATA_WIDTH-1:0] dmi_resp_data_i,
  input  logic [1:0]            dmi_resp_resp_i
);

  localparam int CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_INT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2} dmi_op_t;

  state_t                state, state_next;
  dmi_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            status_q;
  logic                  timeout_q;
  logic                  stale_q;
  logic [CNT_W-1:0]      cnt;

  logic cmd_fire, resp_fire, stale_hit, timeout_hit;

  assign cmd_fire  = (state == IDLE) && cmd_valid_i;
  assign resp_fire = (state == WAIT_RSP) && dmi_resp_valid_i;
  assign stale_hit = (state == IDLE) && dmi_resp_valid_i;
  // Fires in the last allowed wait cycle, so DONE follows exactly
  // TIMEOUT_CYCLES cycles after entering WAIT_RSP. A response in that same
  // cycle takes priority.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == WAIT_RSP) &&
                       !dmi_resp_valid_i && (cnt == TO_LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      timeout_q <= 1'b0;
      stale_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_next;

      if (cmd_fire) begin
        op_q    <= cmd_wr_i ? OP_WRITE : OP_READ;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
      end

      if (resp_fire) begin
        rdata_q   <= dmi_resp_data_i;
        status_q  <= dmi_resp_resp_i;
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        status_q  <= 2'd2;
        timeout_q <= 1'b1;
      end

      // A discarded response wins over the clear on acceptance.
      if (stale_hit)     stale_q <= 1'b1;
      else if (cmd_fire) stale_q <= 1'b0;

      // Held at zero outside WAIT_RSP so every wait starts from zero;
      // saturates instead of wrapping.
      if (state != WAIT_RSP)                       cnt <= '0;
      else if (!dmi_resp_valid_i && (cnt != '1))   cnt <= cnt + CNT_W'(1);
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next       = state;
    cmd_ready_o      = 1'b0;
    busy_o           = 1'b1;
    dmi_req_valid_o  = 1'b0;
    dmi_req_op_o     = OP_NOP;
    dmi_resp_ready_o = 1'b0;
    rsp_valid_o      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready_o      = 1'b1;
        busy_o           = 1'b0;
        dmi_resp_ready_o = 1'b1;   // drain unsolicited responses
        if (cmd_valid_i) state_next = REQ;
      end
      REQ: begin
        dmi_req_valid_o = 1'b1;
        dmi_req_op_o    = op_q;
        if (dmi_req_ready_i) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i || timeout_hit) state_next = DONE;
      end
      DONE: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dmi_req_addr_o = addr_q;
  assign dmi_req_data_o = wdata_q;
  assign rsp_rdata_o    = rdata_q;
  assign rsp_status_o   = status_q;
  assign rsp_timeout_o  = timeout_q;
  assign stale_o        = stale_q;

endmodule

// File: tb/tb_tapasco_dmi_initiator.sv
// tb_tapasco_dmi_initiator
//
// Directed bench for tapasco_dmi_initiator with TIMEOUT_CYCLES = 8.
// Inputs are driven and outputs sampled on the falling clock edge; every
// expected host result is pushed to a scoreboard queue when the command is
// issued and popped when the DUT presents rsp_valid_o.
module tb_tapasco_dmi_initiator;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    status;
    logic          timeout;
  } rsp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_wr_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [DW-1:0] cmd_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic [1:0]    rsp_status_o;
  logic          rsp_timeout_o;
  logic          busy_o;
  logic          stale_o;
  logic          dmi_req_valid_o;
  logic          dmi_req_ready_i = 1'b0;
  logic [1:0]    dmi_req_op_o;
  logic [AW-1:0] dmi_req_addr_o;
  logic [DW-1:0] dmi_req_data_o;
  logic          dmi_resp_valid_i = 1'b0;
  logic          dmi_resp_ready_o;
  logic [DW-1:0] dmi_resp_data_i = '0;
  logic [1:0]    dmi_resp_resp_i = '0;

  tapasco_dmi_initiator #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_wr_i         (cmd_wr_i),
    .cmd_addr_i       (cmd_addr_i),
    .cmd_wdata_i      (cmd_wdata_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_status_o     (rsp_status_o),
    .rsp_timeout_o    (rsp_timeout_o),
    .busy_o           (busy_o),
    .stale_o          (stale_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_op_o     (dmi_req_op_o),
    .dmi_req_addr_o   (dmi_req_addr_o),
    .dmi_req_data_o   (dmi_req_data_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_data_i  (dmi_resp_data_i),
    .dmi_resp_resp_i  (dmi_resp_resp_i)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t sb[$];
  logic [DW-1:0] model_rdata = '0;  // last rdata the host should see

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic expect_rsp(input logic [DW-1:0] rdata, input logic [1:0] status,
                            input logic timeout);
    rsp_t e;
    e.rdata   = rdata;
    e.status  = status;
    e.timeout = timeout;
    sb.push_back(e);
    if (!timeout) model_rdata = rdata;
  endtask

  // Compare the presented result with the scoreboard head, then take it.
  task automatic consume(input string tag);
    rsp_t e;
    check({tag, "_rsp_valid"}, rsp_valid_o, 1'b1);
    check({tag, "_sb_has_entry"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"},   rsp_rdata_o,   e.rdata);
      check({tag, "_status"},  rsp_status_o,  e.status);
      check({tag, "_timeout"}, rsp_timeout_o, e.timeout);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check({tag, "_back_idle"}, {cmd_ready_o, busy_o, rsp_valid_o}, 3'b100);
  endtask

  // Present a command for one cycle (must be in IDLE at call time).
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_valid_i = 1'b1;
    cmd_wr_i    = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    step();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    // Reset state
    repeat (2) step();
    rst_i = 1'b0;
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_outputs",
          {busy_o, rsp_valid_o, rsp_timeout_o, stale_o, dmi_req_valid_o, dmi_req_op_o, rsp_status_o},
          9'b0);
    check("rst_rdata", rsp_rdata_o, 32'h0);

    // Read, immediate ready and response
    dmi_req_ready_i = 1'b1;
    expect_rsp(32'h0000_00AB, 2'd0, 1'b0);
    issue(1'b0, 7'h05, 32'h0);
    check("t1_req", {dmi_req_valid_o, dmi_req_op_o, dmi_req_addr_o}, {1'b1, 2'd1, 7'h05});
    check("t1_no_rsp_c1", rsp_valid_o, 1'b0);
    step();
    check("t1_op_one_cycle", {dmi_req_valid_o, dmi_req_op_o}, 3'b000);
    check("t1_resp_ready", dmi_resp_ready_o, 1'b1);
    check("t1_no_rsp_c2", rsp_valid_o, 1'b0);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'h0000_00AB;
    dmi_resp_resp_i  = 2'd0;
    step();
    dmi_resp_valid_i = 1'b0;
    consume("t1");

    // Write with request ready held low for 5 cycles, busy response
    dmi_req_ready_i = 1'b0;
    expect_rsp(32'h0000_1234, 2'd3, 1'b0);
    issue(1'b1, 7'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_payload_%0d", i),
            {dmi_req_valid_o, dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o},
            {1'b1, 2'd2, 7'h10, 32'hDEAD_BEEF});
      dmi_req_ready_i = (i == 5);
      step();
    end
    dmi_req_ready_i = 1'b0;
    check("t2_req_dropped", {dmi_req_valid_o, dmi_req_op_o}, 3'b000);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'h0000_1234;
    dmi_resp_resp_i  = 2'd3;
    step();
    dmi_resp_valid_i = 1'b0;
    consume("t2");

    // Timeout with no response; rdata keeps the previous value
    dmi_req_ready_i = 1'b1;
    expect_rsp(model_rdata, 2'd2, 1'b1);
    issue(1'b0, 7'h22, 32'h0);
    step();  // now in WAIT_RSP
    waited = 0;
    while (!rsp_valid_o && waited < 4 * TO) begin
      step();
      waited++;
    end
    check("t3_timeout_latency", waited, TO);
    consume("t3");
    check("t3_no_stale_yet", stale_o, 1'b0);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'hCAFE_0000;
    step();
    dmi_resp_valid_i = 1'b0;
    check("t3_late_resp_stale", {stale_o, rsp_valid_o, cmd_ready_o}, 3'b101);
    check("t3_late_resp_discarded", rsp_rdata_o, model_rdata);

    // Response in the timeout cycle wins; acceptance clears stale
    expect_rsp(32'h0000_5A5A, 2'd0, 1'b0);
    issue(1'b0, 7'h01, 32'h0);
    check("t4_stale_cleared", stale_o, 1'b0);
    step();  // now in WAIT_RSP
    repeat (TO - 1) step();
    check("t4_no_early_rsp", rsp_valid_o, 1'b0);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'h0000_5A5A;
    dmi_resp_resp_i  = 2'd0;
    step();
    dmi_resp_valid_i = 1'b0;
    consume("t4");

    // Stale response coinciding with acceptance; host holds off 10 cycles
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'hFFFF_FFFF;
    dmi_resp_resp_i  = 2'd2;
    expect_rsp(32'h0000_0077, 2'd0, 1'b0);
    issue(1'b0, 7'h02, 32'h0);
    dmi_resp_valid_i = 1'b0;
    check("t5_stale_coincide", stale_o, 1'b1);
    step();
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'h0000_0077;
    dmi_resp_resp_i  = 2'd0;
    step();
    dmi_resp_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t5_hold_%0d", i), {rsp_valid_o, cmd_ready_o}, 2'b10);
      cmd_valid_i = (i == 4);
      cmd_addr_i  = 7'h33;
      step();
    end
    cmd_valid_i = 1'b0;
    consume("t5");
    step();
    check("t5_pulse_ignored", {busy_o, dmi_req_valid_o}, 2'b00);

    // Reset while waiting for a response
    issue(1'b0, 7'h04, 32'h0);
    step();  // now in WAIT_RSP
    check("t6_busy_before_rst", busy_o, 1'b1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    model_rdata = '0;
    check("t6_after_rst", {busy_o, cmd_ready_o, rsp_valid_o, stale_o}, 4'b0100);
    check("t6_rdata_cleared", rsp_rdata_o, model_rdata);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'h0000_0099;
    step();
    dmi_resp_valid_i = 1'b0;
    check("t6_stale_no_rsp", {stale_o, rsp_valid_o, busy_o}, 3'b100);
    check("t6_rdata_untouched", rsp_rdata_o, model_rdata);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
